serial_sub11: RTL and testbench

SERIAL_SUB11 -- requirements
Module: serial_sub11

---
 rtl/serial_sub11.sv | 148 ++++++++++++++
 tb/tb_serial_sub11.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub11.sv
// serial_sub11: bit-serial signed subtractor, diff = a - b (exact, 11 bits).
// One full-add cell computes a_i + ~b_i + carry per SHIFT cycle, LSB first,
// with bit 10 formed from the sign-extended operands.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   operand handshake (a, b: 10-bit signed)
//   out_valid/out_ready result handshake (diff: 11-bit signed)
//   busy                high while in SHIFT or DONE
//   ovf10               result does not fit 10-bit signed
//                       (present only with SERIAL_SUB11_OVF_FLAG_EN defined)
module serial_sub11 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [9:0]  a,
  input  logic [9:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [10:0] diff,
`ifdef SERIAL_SUB11_OVF_FLAG_EN
  output logic        ovf10,
`endif
  output logic        busy
);

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 11;
  localparam int unsigned IW = 4;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   a_q, a_d, b_q, b_d;
  logic            carry_q, carry_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [DW-1:0]   diff_q, diff_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;
`ifdef SERIAL_SUB11_OVF_FLAG_EN
  logic            ovf_q, ovf_d;
`endif

  logic [DW-1:0]   a_ext, b_ext;
  logic            op_a, op_b, sum, cout;

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      diff_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SERIAL_SUB11_OVF_FLAG_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      diff_q      <= diff_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef SERIAL_SUB11_OVF_FLAG_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    diff_d  = diff_q;
`ifdef SERIAL_SUB11_OVF_FLAG_EN
    ovf_d   = ovf_q;
`endif

    // Sign extension makes index 10 select a[9] / b[9]
    a_ext = {a_q[AW-1], a_q};
    b_ext = {b_q[AW-1], b_q};
    op_a  = a_ext[idx_q];
    op_b  = ~b_ext[idx_q];
    sum   = op_a ^ op_b ^ carry_q;
    cout  = (op_a & op_b) | (carry_q & (op_a ^ op_b));

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = 1'b1;
          idx_d   = '0;
          diff_d  = '0;
`ifdef SERIAL_SUB11_OVF_FLAG_EN
          ovf_d   = 1'b0;
`endif
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        diff_d[idx_q] = sum;
        carry_d       = cout;
        if (idx_q == IW'(DW - 1)) begin
          state_d = DONE;
`ifdef SERIAL_SUB11_OVF_FLAG_EN
          ovf_d   = sum ^ diff_q[AW-1];
`endif
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        // out_ready only counts once out_valid is actually visible
        if (out_valid_q && out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    // out_valid rises one edge after DONE is entered and drops on handshake
    out_valid_d = (state_q == DONE) && (state_d == DONE);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign diff      = diff_q;
`ifdef SERIAL_SUB11_OVF_FLAG_EN
  assign ovf10     = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub11.sv
// Directed testbench for serial_sub11.
module tb_serial_sub11;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  a;
  logic [9:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] diff;
  logic        busy;
`ifdef SERIAL_SUB11_OVF_FLAG_EN
  logic        ovf10;
`endif

  int checks = 0;
  int errors = 0;

  serial_sub11 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
`ifdef SERIAL_SUB11_OVF_FLAG_EN
    .ovf10     (ovf10),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one operand pair for a single edge (caller ensures in_ready=1)
  task automatic accept(input logic [9:0] av, input logic [9:0] bv);
    a = av;
    b = bv;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Count edges until out_valid (bounded); snapshot diff after the 2nd edge
  task automatic wait_valid(output int n, output logic [10:0] d2);
    n  = 0;
    d2 = '0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
      if (n == 2) d2 = diff;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;       // reset must win over an offered operand
    a = 10'd5;
    b = 10'd3;
    out_ready = 1'b0;
    tick();
    tick();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || diff !== 11'h000) begin
      errors++;
      $display("FAIL reset: in_ready=%b out_valid=%b busy=%b diff=%h, want 1 0 0 000",
               in_ready, out_valid, busy, diff);
    end
`ifdef SERIAL_SUB11_OVF_FLAG_EN
    checks++;
    if (ovf10 !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf: ovf10=%b want 0", ovf10);
    end
`endif
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int n;
    logic [10:0] d2;
    out_ready = 1'b0;
    accept(10'd5, 10'd3);
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_accept: in_ready=%b busy=%b want 0 1", in_ready, busy);
    end
    wait_valid(n, d2);
    checks++;
    if (n != 12) begin
      errors++;
      $display("FAIL basic_latency: edges=%0d want 12", n);
    end
    checks++;
    if (diff !== 11'h002) begin
      errors++;
      $display("FAIL basic_diff: diff=%h want 002", diff);
    end
`ifdef SERIAL_SUB11_OVF_FLAG_EN
    checks++;
    if (ovf10 !== 1'b0) begin
      errors++;
      $display("FAIL basic_ovf: ovf10=%b want 0", ovf10);
    end
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || diff !== 11'h002) begin
      errors++;
      $display("FAIL basic_handshake: in_ready=%b out_valid=%b busy=%b diff=%h want 1 0 0 002",
               in_ready, out_valid, busy, diff);
    end
  endtask

  task automatic test_extremes();
    int n;
    logic [10:0] d2;
    logic [9:0]  av [2];
    logic [9:0]  bv [2];
    logic [10:0] ev [2];
    av[0] = 10'h200; bv[0] = 10'h1FF; ev[0] = 11'h401;
    av[1] = 10'h000; bv[1] = 10'h200; ev[1] = 11'h200;
    for (int k = 0; k < 2; k++) begin
      out_ready = 1'b0;
      accept(av[k], bv[k]);
      wait_valid(n, d2);
      checks++;
      if (n != 12 || diff !== ev[k]) begin
        errors++;
        $display("FAIL extreme%0d: edges=%0d diff=%h want 12 %h", k, n, diff, ev[k]);
      end
`ifdef SERIAL_SUB11_OVF_FLAG_EN
      checks++;
      if (ovf10 !== 1'b1) begin
        errors++;
        $display("FAIL extreme%0d_ovf: ovf10=%b want 1", k, ovf10);
      end
`endif
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    int n;
    logic [10:0] d2;
    out_ready = 1'b0;
    accept(10'h3FF, 10'h001);
    wait_valid(n, d2);
    checks++;
    if (n != 12) begin
      errors++;
      $display("FAIL bp_latency: edges=%0d want 12", n);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (out_valid !== 1'b1 || diff !== 11'h7FE || in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold%0d: out_valid=%b diff=%h in_ready=%b busy=%b want 1 7fe 0 1",
                 k, out_valid, diff, in_ready, busy);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 11'h7FE) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b diff=%h want 1 0 7fe",
               in_ready, out_valid, diff);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [10:0] d2;
    // in_valid and out_ready held high throughout
    a = 10'h3FD;   // -3
    b = 10'd4;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    wait_valid(n, d2);
    checks++;
    if (n != 12 || diff !== 11'h7F9) begin
      errors++;
      $display("FAIL b2b_first: edges=%0d diff=%h want 12 7f9", n, diff);
    end
    a = 10'd200;
    b = 10'd100;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_handshake: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_reaccept: in_ready=%b busy=%b want 0 1", in_ready, busy);
    end
    wait_valid(n, d2);
    checks++;
    if (n != 12 || diff !== 11'h064) begin
      errors++;
      $display("FAIL b2b_second: edges=%0d diff=%h want 12 064", n, diff);
    end
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    logic [10:0] d2;
    out_ready = 1'b0;
    accept(10'h155, 10'h0AA);
    for (int k = 0; k < 5; k++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 11'h000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset: in_ready=%b out_valid=%b diff=%h busy=%b want 1 0 000 0",
               in_ready, out_valid, diff, busy);
    end
    n = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (out_valid) n++;
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL midreset_no_valid: out_valid cycles=%0d want 0", n);
    end
    accept(10'd7, 10'd9);
    wait_valid(n, d2);
    checks++;
    if (d2 !== 11'h002) begin
      errors++;
      $display("FAIL partial_bits: diff after 2 shifts=%h want 002", d2);
    end
    checks++;
    if (n != 12 || diff !== 11'h7FE) begin
      errors++;
      $display("FAIL after_midreset: edges=%0d diff=%h want 12 7fe", n, diff);
    end
`ifdef SERIAL_SUB11_OVF_FLAG_EN
    checks++;
    if (ovf10 !== 1'b0) begin
      errors++;
      $display("FAIL after_midreset_ovf: ovf10=%b want 0", ovf10);
    end
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_input_change();
    int n;
    out_ready = 1'b0;
    accept(10'd100, 10'h3E4);   // b = -28
    n = 0;
    while (!out_valid && n < 40) begin
      a = 10'($urandom);
      b = 10'($urandom);
      in_valid = 1'($urandom);
      tick();
      n++;
    end
    in_valid = 1'b0;
    checks++;
    if (n != 12 || diff !== 11'h080) begin
      errors++;
      $display("FAIL input_change: edges=%0d diff=%h want 12 080", n, diff);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    test_reset();
    test_basic();
    test_extremes();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_input_change();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
